// File: rtl/dragrace_pkg.sv
// Shared definitions for the drag-race timer: FSM encodings, segment patterns
// and a BCD increment helper used by the elapsed-time counter.
package dragrace_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    TIMING = 3'd2,
    DONE   = 3'd3,
    FOUL   = 3'd4
  } state_t;

  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [15:0] BCD_MAX  = 16'h9999;

  // Four-digit BCD +1 with ripple carry; digit 0 (bits 3:0) is the units digit.
  function automatic logic [15:0] bcd_inc(input logic [15:0] d);
    logic [15:0] r;
    logic        carry;
    r     = d;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (d[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[i*4 +: 4] = d[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[i*4 +: 4] = d[i*4 +: 4];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/race_timer_if.sv
// Signal bundle between the light tree / stage beam side and the race timer.
interface race_timer_if;
  import dragrace_pkg::*;

  logic       SB;
  logic       Green;
  logic       Red;
  logic [0:6] HEX0;
  logic [0:6] HEX1;
  logic [0:6] HEX2;
  logic [0:6] HEX3;
  logic       Done;
  logic       Foul;
  logic       Overflow;

  modport master (
    output SB, Green, Red,
    input  HEX0, HEX1, HEX2, HEX3, Done, Foul, Overflow
  );

  modport slave (
    input  SB, Green, Red,
    output HEX0, HEX1, HEX2, HEX3, Done, Foul, Overflow
  );

endinterface

// File: rtl/bcd_to_seg.sv
// One BCD digit to active-low seven-segment pattern (index 0 = segment a).
module bcd_to_seg
  import dragrace_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [0:6] seg
);

  // Segment lookup; codes above 9 blank the digit.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/race_timer.sv
// Reaction timer: counts milliseconds from green rise until the car leaves the
// beam, flags fouls and overflow, and shows the result on four seven-segment digits.
module race_timer
  import dragrace_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int TICK_W   = 16
)(
  input  logic         Clock,
  input  logic         Rst,
  race_timer_if.slave  bus
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_t            state_r, state_nxt;
  logic [TICK_W-1:0] presc_r, presc_nxt;
  logic [15:0]       digits_r, digits_nxt;
  logic              done_r, done_nxt;
  logic              foul_r, foul_nxt;
  logic              ovf_r, ovf_nxt;
  logic              green_d_r;
  logic              sb_meta_r;
  logic              sb_s_r;
  logic              green_rise_s;
  logic              tick_s;
  logic              restage_s;
  logic [0:6]        seg0_s, seg1_s, seg2_s, seg3_s;

  assign green_rise_s = bus.Green & ~green_d_r;
  assign tick_s       = (presc_r == TICK_LAST);
  assign restage_s    = sb_s_r & ~bus.Green & ~bus.Red;

  // Beam synchronizer and green edge history.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      sb_meta_r <= 1'b0;
      sb_s_r    <= 1'b0;
      green_d_r <= 1'b0;
    end else begin
      sb_meta_r <= bus.SB;
      sb_s_r    <= sb_meta_r;
      green_d_r <= bus.Green;
    end
  end

  // FSM state, prescaler, digits and result flags.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_r  <= IDLE;
      presc_r  <= '0;
      digits_r <= 16'h0000;
      done_r   <= 1'b0;
      foul_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      presc_r  <= presc_nxt;
      digits_r <= digits_nxt;
      done_r   <= done_nxt;
      foul_r   <= foul_nxt;
      ovf_r    <= ovf_nxt;
    end
  end

  // Next-state logic; beam loss outranks red, which outranks a pending tick.
  always_comb begin
    state_nxt  = state_r;
    presc_nxt  = presc_r;
    digits_nxt = digits_r;
    done_nxt   = done_r;
    foul_nxt   = foul_r;
    ovf_nxt    = ovf_r;
    case (state_r)
      IDLE: begin
        if (sb_s_r) begin
          state_nxt = ARMED;
        end else begin
          state_nxt = IDLE;
        end
      end
      ARMED: begin
        if (bus.Red) begin
          state_nxt = FOUL;
          foul_nxt  = 1'b1;
        end else if (green_rise_s) begin
          state_nxt  = TIMING;
          presc_nxt  = '0;
          digits_nxt = 16'h0000;
          ovf_nxt    = 1'b0;
          done_nxt   = 1'b0;
        end else if (!sb_s_r) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = ARMED;
        end
      end
      TIMING: begin
        if (!sb_s_r) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else if (bus.Red) begin
          state_nxt = FOUL;
          foul_nxt  = 1'b1;
        end else if (tick_s) begin
          presc_nxt = '0;
          if (digits_r == BCD_MAX) begin
            ovf_nxt   = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end else begin
            digits_nxt = bcd_inc(digits_r);
            state_nxt  = TIMING;
          end
        end else begin
          presc_nxt = presc_r + TICK_W'(1);
          state_nxt = TIMING;
        end
      end
      DONE: begin
        if (restage_s) begin
          state_nxt = ARMED;
          done_nxt  = 1'b0;
        end else begin
          state_nxt = DONE;
        end
      end
      FOUL: begin
        if (restage_s) begin
          state_nxt = ARMED;
          foul_nxt  = 1'b0;
        end else begin
          state_nxt = FOUL;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  bcd_to_seg u_seg0 (.bcd(digits_r[3:0]),   .seg(seg0_s));
  bcd_to_seg u_seg1 (.bcd(digits_r[7:4]),   .seg(seg1_s));
  bcd_to_seg u_seg2 (.bcd(digits_r[11:8]),  .seg(seg2_s));
  bcd_to_seg u_seg3 (.bcd(digits_r[15:12]), .seg(seg3_s));

  assign bus.HEX0     = (state_r == FOUL) ? SEG_DASH : seg0_s;
  assign bus.HEX1     = (state_r == FOUL) ? SEG_DASH : seg1_s;
  assign bus.HEX2     = (state_r == FOUL) ? SEG_DASH : seg2_s;
  assign bus.HEX3     = (state_r == FOUL) ? SEG_DASH : seg3_s;
  assign bus.Done     = done_r;
  assign bus.Foul     = foul_r;
  assign bus.Overflow = ovf_r;

endmodule

// File: doc/race_timer.md
Name: race_timer

Overview:
- Reaction/elapsed timer sitting directly downstream of the drag-race light-tree FSM; consumes its Green and Red light outputs plus the stage beam.
- Measures milliseconds from the Green light turning on to the car leaving the beam (SB falling). Flags a foul if Red lights first.
- Drives the result as 4 BCD digits on HEX3..HEX0 of the DE2 board.

Parameters:
- TICK_DIV, 50000, Clock cycles per 1 ms tick (50 MHz); benches use 4.
- TICK_W, 16, prescaler width; must satisfy 2^TICK_W > TICK_DIV.

Ports:
- Clock  in  1  system clock (CLOCK_50 domain, same as light tree)
- Rst  in  1  asynchronous, active-low reset
- SB  in  1  stage beam, 1 = car staged; asynchronous switch input
- Green  in  1  green light from tree FSM, synchronous to Clock
- Red  in  1  red (foul) light from tree FSM, synchronous to Clock
- HEX0..HEX3  out  [0:6] each  active-low segments a..g; HEX3 = thousands ms, HEX0 = units ms
- Done  out  1  result valid and frozen
- Foul  out  1  red light seen before green
- Overflow  out  1  count saturated at 9999 ms

Behaviour:
- Reset (Rst=0, async): state IDLE, prescaler 0, BCD digits 0000, Done=Foul=Overflow=0, Green_d=0, sync flops 0. HEX shows "0000".
- SB passes through a 2-flop synchronizer (SB_s); 2-cycle latency. Green and Red are used unsynchronized. Green_d is a 1-cycle delayed copy; green rise = Green & ~Green_d.
- States: IDLE, ARMED, TIMING, DONE, FOUL.
- IDLE: SB_s=1 -> ARMED. Digits unchanged.
- ARMED:
  - Red=1 -> FOUL, Foul=1. Red has priority over a green rise in the same cycle.
  - Else green rise -> TIMING: prescaler<=0, digits<=0000, Overflow<=0, Done<=0.
  - Else SB_s=0 -> IDLE.
- TIMING:
  - Prescaler counts 0..TICK_DIV-1 and wraps. A tick fires on the cycle it equals TICK_DIV-1; the digits increment by 1 ms in BCD, with ripple carry units -> tens -> hundreds -> thousands, each digit 9 -> 0.
  - SB_s=0 -> DONE, Done=1, digits frozen. A tick in the same cycle is discarded.
  - Red=1 -> FOUL, Foul=1. Priority: SB_s=0 over Red.
  - Tick while digits=9999 -> digits stay 9999, Overflow=1, -> DONE, Done=1.
- DONE: holds digits and flags. SB_s=1 while Green=0 and Red=0 -> ARMED, Done=0, digits still displayed.
- FOUL: HEX3..HEX0 each show dash (7'b1111110). Foul stays 1. SB_s=1 while Green=0 and Red=0 -> ARMED, Foul=0.
- Display: combinational decode of digits (or dash in FOUL) to HEX; all other outputs registered.
- Default/illegal state -> IDLE.
- Reset mid-TIMING clears everything immediately, with no dependence on Clock.

Decomposition:
- Shared package (dragrace_pkg): state encodings (IDLE=3'd0, ARMED=3'd1, TIMING=3'd2, DONE=3'd3, FOUL=3'd4) and segment constants SEG_DASH=7'b1111110, SEG_BLANK=7'b1111111.
- One sub-module: bcd_to_seg (4-bit BCD in, [0:6] active-low segments out, non-BCD codes -> SEG_BLANK), instantiated four times.
- Prescaler, BCD chain and FSM stay in race_timer.

Test Plan (TICK_DIV=4):
- Reset mid-count: assert Rst=0 during TIMING with digits 0012 -> same cycle Done=0, HEX = "0000", state IDLE.
- Normal run: SB=1, Green rises, hold 4*37 cycles, drop SB -> Done=1 (plus 2-cycle sync latency), digits 0037, HEX0=seg(7), HEX1=seg(3), HEX2=HEX3=seg(0).
- Carry ripple: run to 0999, one more tick -> 1000; SB drop on the exact tick cycle -> count not incremented.
- Foul: SB=1, Red=1 before Green -> Foul=1, all HEX = 7'b1111110. Restage with Green=Red=0 -> Foul=0, state ARMED.
- Overflow: hold beyond 9999 ticks -> digits 9999, Overflow=1, Done=1. Further ticks cause no change.
